fwrisc_iprefetch: RTL and testbench

- Instruction prefetch buffer between the fwrisc core instruction port (iaddr/ivalid/iready/idata) and the instruction memory bus.
- Holds up to DEPTH sequential 32-bit words starting at the core's current fetch address, so sequential fetches complete in zero wait cycles.
- On a non-sequential fetch (branch/jump/trap) it flushes and refetches from the new address.

---
 rtl/fwrisc_iprefetch.sv | 146 ++++++++++++++
 tb/tb_fwrisc_iprefetch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_iprefetch.sv
// Instruction prefetch buffer between the fwrisc fetch port and the instruction memory bus.
// Keeps up to DEPTH sequential words ahead of the core; non-sequential fetches flush and refetch.
module fwrisc_iprefetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              iaddr,
  input  logic                     ivalid,
  output logic                     iready,
  output logic [31:0]              idata,
  output logic [31:0]              maddr,
  output logic                     mvalid,
  input  logic                     mready,
  input  logic [31:0]              mrdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_buf [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [29:0]   r_head_waddr;
  logic [29:0]   r_req_waddr;
  logic          r_discard;
  logic          r_active;
  logic          r_mvalid;
  logic [31:0]   r_maddr;

  logic [29:0]   w_waddr;
  logic          w_hit;
  logic          w_wait;
  logic          w_miss;
  logic          w_accept;
  logic          w_hold;
  logic          w_fill;

  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [29:0]   w_head_waddr_nxt;
  logic [29:0]   w_req_waddr_nxt;
  logic          w_discard_nxt;
  logic          w_active_nxt;
  logic          w_mvalid_nxt;
  logic [31:0]   w_maddr_nxt;

  // Fetches are word-aligned; the low address bits carry no information here.
  logic w_unused_addr;
  assign w_unused_addr = ^iaddr[1:0];

  assign w_waddr  = iaddr[31:2];
  assign w_hit    = ivalid && (r_count != '0) && (w_waddr == r_head_waddr);
  assign w_wait   = ivalid && (r_count == '0) && r_active && !r_discard &&
                    (r_req_waddr == w_waddr);
  assign w_miss   = ivalid && !w_hit && !w_wait;
  assign w_accept = r_mvalid && mready;
  assign w_hold   = r_mvalid && !mready;
  // A flush in the same cycle as an accept wins: that data belongs to the old stream.
  assign w_fill   = w_accept && !r_discard && !w_miss;

  always_comb begin
    w_rd_ptr_nxt     = r_rd_ptr;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_count_nxt      = r_count;
    w_head_waddr_nxt = r_head_waddr;
    w_req_waddr_nxt  = r_req_waddr;
    w_discard_nxt    = r_discard;
    w_active_nxt     = r_active;

    if (w_miss) begin
      w_count_nxt      = '0;
      w_rd_ptr_nxt     = r_wr_ptr;
      w_head_waddr_nxt = w_waddr;
      w_req_waddr_nxt  = w_waddr;
      w_active_nxt     = 1'b1;
      // A request stuck on the bus cannot be withdrawn; its data is dropped when it lands.
      w_discard_nxt    = w_hold;
    end else begin
      if (w_accept && r_discard) begin
        w_discard_nxt = 1'b0;
      end
      if (w_hit) begin
        w_rd_ptr_nxt     = r_rd_ptr + PW'(1);
        w_head_waddr_nxt = r_head_waddr + 30'd1;
      end
      if (w_fill) begin
        w_wr_ptr_nxt    = r_wr_ptr + PW'(1);
        w_req_waddr_nxt = r_req_waddr + 30'd1;
      end
      w_count_nxt = r_count + CW'(w_fill) - CW'(w_hit);
    end
  end

  always_comb begin
    if (w_hold) begin
      w_mvalid_nxt = 1'b1;
      w_maddr_nxt  = r_maddr;
    end else begin
      // Only one request can be outstanding, so space is judged on the buffered count alone.
      w_mvalid_nxt = w_active_nxt && (w_count_nxt < CW'(DEPTH));
      w_maddr_nxt  = {w_req_waddr_nxt, 2'b00};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_waddr <= '0;
      r_req_waddr  <= '0;
      r_discard    <= 1'b0;
      r_active     <= 1'b0;
      r_mvalid     <= 1'b0;
      r_maddr      <= '0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_count      <= w_count_nxt;
      r_head_waddr <= w_head_waddr_nxt;
      r_req_waddr  <= w_req_waddr_nxt;
      r_discard    <= w_discard_nxt;
      r_active     <= w_active_nxt;
      r_mvalid     <= w_mvalid_nxt;
      r_maddr      <= w_maddr_nxt;
    end
  end

  // Storage needs no reset: every read is masked by a non-zero count.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_buf[r_wr_ptr] <= mrdata;
    end
  end

  assign iready = w_hit;
  assign idata  = w_hit ? r_buf[r_rd_ptr] : 32'h0;
  assign maddr  = r_maddr;
  assign mvalid = r_mvalid;
  assign level  = r_count;

endmodule

// File: tb/tb_fwrisc_iprefetch.sv
// Bench for fwrisc_iprefetch: directed scenarios plus a random core/memory mix,
// checked against a queue model of buffered word addresses.
module tb_fwrisc_iprefetch;

  localparam int unsigned DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   iaddr;
  logic          ivalid;
  logic          iready;
  logic [31:0]   idata;
  logic [31:0]   maddr;
  logic          mvalid;
  logic          mready;
  logic [31:0]   mrdata;
  logic [LW-1:0] level;

  always #5 clock = ~clock;

  fwrisc_iprefetch #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .iaddr  (iaddr),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .maddr  (maddr),
    .mvalid (mvalid),
    .mready (mready),
    .mrdata (mrdata),
    .level  (level)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: words held for the core, next word to fetch, stale in-flight request.
  logic [29:0] q[$];
  logic [29:0] m_next;
  bit          m_active;
  bit          m_stale;
  bit          exp_mv;
  logic [31:0] exp_maddr;

  // Memory behaviour knobs
  int          delay;
  int          wait_cyc;
  bit          rand_mem;
  logic [31:0] stall_addr;
  int          stall_cnt;
  logic [31:0] acc_log[$];
  bit          saw_ready;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return {w[13:0], 2'b01, w[29:14]} ^ 32'hA5C3_1E0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_next    = '0;
    m_active  = 1'b0;
    m_stale   = 1'b0;
    exp_mv    = 1'b0;
    exp_maddr = '0;
    wait_cyc  = 0;
    stall_cnt = 0;
  endtask

  task automatic tick();
    logic [29:0] wa;
    bit exp_hit, wait_ok, held, accept, miss, stalled;
    stalled = (stall_cnt > 0) && (maddr == stall_addr);
    if (rand_mem) mready = mvalid && !stalled && ($urandom_range(0, 3) != 0);
    else          mready = mvalid && !stalled && (wait_cyc >= delay);
    mrdata = mready ? mem_word(maddr[31:2]) : $urandom();
    @(negedge clock);
    wa      = iaddr[31:2];
    exp_hit = ivalid && (q.size() > 0) && (q[0] == wa);
    chk("iready", 32'(iready), 32'(exp_hit));
    chk("idata", idata, exp_hit ? mem_word(wa) : 32'h0);
    chk("level", 32'(level), q.size());
    chk("mvalid", 32'(mvalid), 32'(exp_mv));
    if (exp_mv) chk("maddr", maddr, exp_maddr);
    saw_ready = iready;
    held    = exp_mv && !mready;
    accept  = exp_mv && mready;
    wait_ok = (q.size() == 0) && m_active && !m_stale && (m_next == wa);
    miss    = ivalid && !exp_hit && !wait_ok;
    if (accept) acc_log.push_back(maddr);
    if (stalled && mvalid) stall_cnt--;
    if (mvalid && !mready) wait_cyc++;
    else wait_cyc = 0;
    if (miss) begin
      q.delete();
      m_next   = wa;
      m_active = 1'b1;
      m_stale  = held;
    end else begin
      if (exp_hit) void'(q.pop_front());
      if (accept) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          q.push_back(m_next);
          m_next++;
        end
      end
    end
    if (held) exp_mv = 1'b1;
    else begin
      exp_mv    = m_active && (q.size() < DEPTH);
      exp_maddr = {m_next, 2'b00};
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int n);
    ivalid = 1'b1;
    iaddr  = a;
    n      = 0;
    do begin
      tick();
      n++;
    end while (!saw_ready && n < 80);
    chk("fetch_done", 32'(saw_ready), 32'd1);
    ivalid = 1'b0;
  endtask

  task automatic idle(input int k);
    ivalid = 1'b0;
    repeat (k) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [31:0] addr;
    reset  = 1'b0;
    ivalid = 1'b1;
    iaddr  = 32'h100;
    mready = 1'b0;
    mrdata = '0;
    delay  = 1;
    rand_mem = 1'b0;
    model_reset();
    #12;
    chk("rst_iready", 32'(iready), 32'd0);
    chk("rst_idata", idata, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_mvalid", 32'(mvalid), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    ivalid = 1'b0;
    idle(4);

    // First miss with a one-cycle memory, then prefetch until full
    acc_log.delete();
    fetch(32'h100, n);
    chk("miss_latency", n - 1, 32'd3);
    idle(12);
    chk("fill_level", 32'(level), DEPTH);
    chk("fill_mvalid", 32'(mvalid), 32'd0);
    chk("fill_count", acc_log.size(), 32'd5);
    for (int i = 0; i < acc_log.size() && i < 5; i++)
      chk("fill_addr", acc_log[i], 32'h100 + 32'(i) * 4);

    // Sequential stream with a zero-latency memory never waits
    delay = 0;
    for (int i = 1; i < 8; i++) begin
      fetch(32'h100 + 32'(i) * 4, n);
      chk("seq_zero_wait", n, 32'd1);
    end

    // Jump while 0x10C is stuck on the bus
    stall_addr = 32'h10C;
    stall_cnt  = 3;
    fetch(32'h100, n);
    n = 0;
    while (!(mvalid && maddr == 32'h10C) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_10c", 32'(mvalid && maddr == 32'h10C), 32'd1);
    acc_log.delete();
    ivalid = 1'b1;
    iaddr  = 32'h200;
    tick();
    chk("hold_maddr", maddr, 32'h10C);
    chk("hold_mvalid", 32'(mvalid), 32'd1);
    fetch(32'h200, n);
    chk("jump_acc_cnt", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      chk("jump_acc0", acc_log[0], 32'h10C);
      chk("jump_acc1", acc_log[1], 32'h200);
    end

    // Flush in the same cycle that 0x104 is accepted
    n = 0;
    while (!(level == LW'(DEPTH) && !mvalid) && n < 30) begin
      tick();
      n++;
    end
    delay = 1;
    fetch(32'h100, n);
    chk("pre_flush_maddr", maddr, 32'h104);
    acc_log.delete();
    ivalid = 1'b1;
    iaddr  = 32'h400;
    tick();
    chk("flush_acc", acc_log.size(), 32'd1);
    chk("flush_next_mvalid", 32'(mvalid), 32'd1);
    chk("flush_next_maddr", maddr, 32'h400);
    fetch(32'h400, n);
    chk("flush_latency", n, 32'd3);

    // Halfword-aligned fetch of an already-consumed word refetches it
    delay = 0;
    fetch(32'h100, n);
    ivalid = 1'b1;
    iaddr  = 32'h102;
    tick();
    chk("hw_mvalid", 32'(mvalid), 32'd1);
    chk("hw_maddr", maddr, 32'h100);
    fetch(32'h102, n);

    // Address wrap
    fetch(32'hFFFF_FFF8, n);
    fetch(32'hFFFF_FFFC, n);
    fetch(32'h0000_0000, n);
    chk("wrap_seq", n, 32'd1);
    fetch(32'h0000_0004, n);

    // Random core and memory
    rand_mem = 1'b1;
    addr = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) addr = addr + 4;
      else if (r < 7) addr = 32'h1000 + ($urandom_range(0, 63) << 2);
      else if (r < 8) addr = addr + 2;
      else idle($urandom_range(1, 3));
      fetch(addr, n);
    end

    // Asynchronous reset mid-transfer
    rand_mem   = 1'b0;
    delay      = 0;
    stall_cnt  = 0;
    ivalid     = 1'b1;
    iaddr      = 32'h500;
    tick();
    ivalid     = 1'b0;
    stall_addr = 32'h508;
    stall_cnt  = 50;
    n = 0;
    while (!(level == LW'(2) && mvalid) && n < 20) begin
      tick();
      n++;
    end
    chk("pre_reset", 32'(level == LW'(2) && mvalid), 32'd1);
    #2;
    ivalid = 1'b1;
    iaddr  = 32'h500;
    reset  = 1'b0;
    #1;
    chk("async_mvalid", 32'(mvalid), 32'd0);
    chk("async_iready", 32'(iready), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_idata", idata, 32'd0);
    model_reset();
    acc_log.delete();
    @(posedge clock);
    #1;
    reset  = 1'b1;
    ivalid = 1'b0;
    idle(6);
    chk("post_reset_quiet", acc_log.size(), 32'd0);
    fetch(32'h600, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
